// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 32-bit MIPS register file, two combinational reads, one write per clock

module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  R1,
  input  logic [4:0]  R2,
  input  logic [4:0]  W1,
  input  logic [31:0] D1,
  output logic [31:0] Out1,
  output logic [31:0] Out2
);

  // Entry 0 exists only to keep indexing uniform; it is held at zero and
  // the read muxes never select it, so it folds away as a constant.
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next-state: every non-reset edge writes D1 to W1; writes to entry 0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (W1 != 5'd0) begin
      regs_d[W1] = D1;
    end
    regs_d[0] = 32'd0;
  end

  // State register: synchronous reset clears all entries and overrides the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: no bypass, register 0 forced to zero even before the first reset.
  always_comb begin
    Out1 = (R1 == 5'd0) ? 32'd0 : regs_q[R1];
    Out2 = (R2 == 5'd0) ? 32'd0 : regs_q[R2];
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed scoreboard bench for reg_file

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic [4:0]  W1;
  logic [31:0] D1;
  logic [31:0] Out1;
  logic [31:0] Out2;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  reg_file dut (
    .clk  (clk),
    .rst  (rst),
    .R1   (R1),
    .R2   (R2),
    .W1   (W1),
    .D1   (D1),
    .Out1 (Out1),
    .Out2 (Out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_empty obs=%h exp=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  // Set read addresses, queue model values, let the comb reads settle, compare.
  task automatic rd_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    R1 = a;
    R2 = b;
    push_exp($sformatf("%s_out1_r%0d", tag, a), model[a]);
    push_exp($sformatf("%s_out2_r%0d", tag, b), model[b]);
    #1;
    pop_cmp(Out1);
    pop_cmp(Out2);
  endtask

  // One write edge; W1 returns to 0 afterwards so idle edges write nothing.
  task automatic wr(input logic [4:0] w, input logic [31:0] d);
    W1 = w;
    D1 = d;
    @(posedge clk);
    if (w != 5'd0) model[w] = d;
    #1;
    W1 = 5'd0;
  endtask

  task automatic rst_edge(input logic [4:0] w, input logic [31:0] d);
    rst = 1'b1;
    W1  = w;
    D1  = d;
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    rst = 1'b0;
    W1  = 5'd0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) rd_check(tag, 5'(i), 5'(31 - i));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst = 1'b1;
    R1  = 5'd0;
    R2  = 5'd0;
    W1  = 5'd5;
    D1  = 32'hFFFF_FFFF;
    #1;
    push_exp("pre_reset_r0_out1", 32'd0);
    push_exp("pre_reset_r0_out2", 32'd0);
    pop_cmp(Out1);
    pop_cmp(Out2);

    // Reset wins over a write to reg 5
    rst_edge(5'd5, 32'hFFFF_FFFF);
    sweep_zero("reset");
    rd_check("reset_r5", 5'd5, 5'd5);

    // Basic write/read
    W1 = 5'd1;
    D1 = 32'd32;
    rd_check("basic_pre", 5'd1, 5'd3);
    wr(5'd1, 32'd32);
    rd_check("basic_post1", 5'd1, 5'd3);
    wr(5'd3, 32'd25);
    rd_check("basic_post3", 5'd1, 5'd3);

    // Register 0 discards writes
    wr(5'd0, 32'hDEAD_BEEF);
    rd_check("reg0", 5'd0, 5'd0);

    // Full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) rd_check("sweep", 5'(i), 5'(31 - i));

    // Overwrite and read-during-write, no bypass
    wr(5'd7, 32'h11);
    W1 = 5'd7;
    D1 = 32'h22;
    R1 = 5'd7;
    R2 = 5'd7;
    rd_check("rdw_pre", 5'd7, 5'd7);
    wr(5'd7, 32'h22);
    rd_check("rdw_post", 5'd7, 5'd7);

    // Back-to-back writes: last edge wins
    wr(5'd9, 32'hAAAA_0001);
    wr(5'd9, 32'hBBBB_0002);
    rd_check("b2b", 5'd9, 5'd8);

    // Reset mid-run clears everything regardless of W1/D1
    rst_edge(5'd4, 32'h55);
    sweep_zero("midreset");
    wr(5'd4, 32'h55);
    rd_check("post_reset_w4", 5'd4, 5'd5);

    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
